nv_nvdla_mcif_wr_resp: RTL and testbench

Memory-side responder for the DMAIF write-request protocol that SDP WDMA emits toward MCIF. It accepts 66-bit command and data packets, decodes each command into a sequence of 64-bit beat writes on a simple memory write port, and pulses `wr_rsp_complete` when an acknowledged command has fully retired. It terminates `sdp2mcif_wr_req_*` in unit-level and subsystem benches and in the small-config memory-side path.

---
 rtl/nv_nvdla_dmaif_pkg.sv | 29 ++
 rtl/nv_nvdla_mcif_wr_resp_if.sv | 28 ++
 rtl/nv_nvdla_mcif_wr_resp.sv | 94 +++++++++
 tb/tb_nv_nvdla_mcif_wr_resp.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_dmaif_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nv_nvdla_dmaif_pkg : DMAIF write-request packet layout and responder states
// Revision: 1.0
// ---------------------------------------------------------------------------
package nv_nvdla_dmaif_pkg;

  localparam int   PKT_W        = 66;
  localparam int   PKT_TYPE_BIT = 65;
  localparam logic PKT_CMD      = 1'b0;
  localparam logic PKT_DAT      = 1'b1;

  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_ADDR_W   = 32;
  localparam int CMD_SIZE_LSB = 32;
  localparam int CMD_SIZE_W   = 13;
  localparam int CMD_ACK_BIT  = 45;

  localparam int DAT_DATA_LSB = 0;
  localparam int DAT_DATA_W   = 64;
  localparam int DAT_MASK_BIT = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DATA = 1'b1
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/nv_nvdla_mcif_wr_resp_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nv_nvdla_mcif_wr_resp_if : write-request packet bus plus memory write port
// Revision: 1.0
// ---------------------------------------------------------------------------
interface nv_nvdla_mcif_wr_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [65:0]       wr_req_pd;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready;

  modport slave (
    input  wr_req_valid, wr_req_pd, mem_wr_ready,
    output wr_req_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport master (
    output wr_req_valid, wr_req_pd, mem_wr_ready,
    input  wr_req_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/nv_nvdla_mcif_wr_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nv_nvdla_mcif_wr_resp : decodes DMAIF write cmd/data packets into beat writes
// Revision: 1.0
// ---------------------------------------------------------------------------
module nv_nvdla_mcif_wr_resp
  import nv_nvdla_dmaif_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 13
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  nv_nvdla_mcif_wr_resp_if.slave wr,
  output logic                   wr_rsp_complete,
  output logic                   proto_err
);

  wr_state_e         state;
  wr_state_e         state_nxt;
  logic [ADDR_W-1:0] addr_reg;
  logic [SIZE_W-1:0] beats_left;
  logic              ack;

  logic is_dat;
  logic mask;
  logic hs;
  logic cmd_take;
  logic beat_take;
  logic final_beat;
  logic bad_pkt;

  assign is_dat     = (wr.wr_req_pd[PKT_TYPE_BIT] == PKT_DAT);
  assign mask       = wr.wr_req_pd[DAT_MASK_BIT];
  assign hs         = wr.wr_req_valid & wr.wr_req_ready;
  assign cmd_take   = hs & (state == IDLE) & ~is_dat;
  assign beat_take  = hs & (state == DATA) & is_dat;
  assign final_beat = beat_take & (beats_left == '0);
  // Stray packets are still accepted so the upstream never stalls on them.
  assign bad_pkt    = hs & (((state == IDLE) & is_dat) |
                            ((state == DATA) & ~is_dat) |
                            (is_dat & ~mask));

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_take)   state_nxt = DATA;
      DATA:    if (final_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port is a pass-through, so request ready follows memory ready.
  always_comb begin
    wr.wr_req_ready = 1'b1;
    wr.mem_wr_en    = 1'b0;
    if (state == DATA) begin
      if (is_dat) wr.wr_req_ready = wr.mem_wr_ready;
      wr.mem_wr_en = wr.wr_req_valid & is_dat;
    end
  end

  assign wr.mem_wr_addr = addr_reg;
  assign wr.mem_wr_data = wr.wr_req_pd[DAT_DATA_LSB +: DATA_W];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      addr_reg        <= '0;
      beats_left      <= '0;
      ack             <= 1'b0;
      wr_rsp_complete <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      wr_rsp_complete <= final_beat & ack;
      if (cmd_take) begin
        addr_reg   <= {wr.wr_req_pd[CMD_ADDR_LSB + 3 +: ADDR_W - 3], 3'b000};
        beats_left <= wr.wr_req_pd[CMD_SIZE_LSB +: SIZE_W];
        ack        <= wr.wr_req_pd[CMD_ACK_BIT];
      end else if (beat_take) begin
        addr_reg   <= addr_reg + ADDR_W'(8);
        beats_left <= beats_left - SIZE_W'(1);
      end
      if (bad_pkt) proto_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_mcif_wr_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nv_nvdla_mcif_wr_resp : directed and random packets vs a packet-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_nv_nvdla_mcif_wr_resp;

  logic clk;
  logic rstn;
  logic complete;
  logic proto_err;

  nv_nvdla_mcif_wr_resp_if bus ();

  nv_nvdla_mcif_wr_resp dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .wr              (bus),
    .wr_rsp_complete (complete),
    .proto_err       (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory-ready pattern: 0 always ready, 1 random, 2 repeating 1,0,0
  int rdy_mode = 0;
  int pat_idx  = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       bus.mem_wr_ready = 1'($urandom_range(0, 1));
      2: begin bus.mem_wr_ready = (pat_idx % 3 == 0); pat_idx++; end
      default: bus.mem_wr_ready = 1'b1;
    endcase
  end

  // Packet-level reference: one open burst at most, expected write stream
  bit          m_busy  = 0;
  logic [31:0] m_addr  = '0;
  int          m_left  = 0;
  bit          m_ack   = 0;
  bit          m_err   = 0;
  bit          m_pulse = 0;
  int          n_writes = 0;
  int          n_pulses = 0;
  logic [31:0] wlog[$];

  always @(negedge clk) begin
    logic exp_rdy, exp_en, typ;
    typ = bus.wr_req_pd[65];
    if (!rstn) begin
      check("rst_wr_en", bus.mem_wr_en, 0);
      check("rst_complete", complete, 0);
      check("rst_proto_err", proto_err, 0);
      m_busy = 0; m_err = 0; m_pulse = 0; m_left = 0;
    end else begin
      exp_rdy = !m_busy || !typ || bus.mem_wr_ready;
      exp_en  = m_busy && bus.wr_req_valid && typ;
      check("ready", bus.wr_req_ready, exp_rdy);
      check("wr_en", bus.mem_wr_en, exp_en);
      if (exp_en) begin
        check("wr_addr", bus.mem_wr_addr, m_addr);
        check("wr_data", bus.mem_wr_data, bus.wr_req_pd[63:0]);
      end
      check("complete", complete, m_pulse);
      check("proto_err", proto_err, m_err);
      m_pulse = 0;
      if (complete) n_pulses++;
      if (bus.mem_wr_en && bus.mem_wr_ready) wlog.push_back(bus.mem_wr_addr);
      if (bus.wr_req_valid && exp_rdy) begin
        if (!typ) begin
          if (m_busy) m_err = 1;
          else begin
            m_busy = 1;
            m_addr = bus.wr_req_pd[31:0] & 32'hFFFF_FFF8;
            m_left = int'(bus.wr_req_pd[44:32]) + 1;
            m_ack  = bus.wr_req_pd[45];
          end
        end else if (!m_busy) begin
          m_err = 1;
        end else begin
          if (!bus.wr_req_pd[64]) m_err = 1;
          n_writes++;
          m_addr = m_addr + 32'd8;
          m_left--;
          if (m_left == 0) begin
            m_busy  = 0;
            m_pulse = m_ack;
          end
        end
      end
    end
  end

  function automatic logic [65:0] cmd(input logic [31:0] a, input int size, input bit ack);
    logic [12:0] s;
    s = 13'(size);
    return {1'b0, 19'b0, ack, s, a};
  endfunction

  function automatic logic [65:0] dat(input logic [63:0] d, input bit m);
    return {1'b1, m, d};
  endfunction

  task automatic send(input logic [65:0] p);
    int n;
    bus.wr_req_valid = 1'b1;
    bus.wr_req_pd    = p;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.wr_req_ready) break;
      n++;
      if (n > 200) begin
        check("hs_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.wr_req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.wr_req_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic burst(input logic [31:0] a, input int size, input bit ack);
    send(cmd(a, size, ack));
    for (int i = 0; i <= size; i++) send(dat({$urandom, $urandom}, 1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, p0;
    rstn = 1'b0;
    bus.wr_req_valid = 1'b0;
    bus.wr_req_pd    = '0;
    bus.mem_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);

    // single-beat acked command
    wlog.delete(); w0 = n_writes; p0 = n_pulses;
    send(cmd(32'h1000, 0, 1));
    send(dat(64'hDEADBEEF_00000001, 1'b1));
    idle(3);
    check("t1_writes", wlog.size(), 1);
    if (wlog.size() > 0) check("t1_addr", wlog[0], 32'h1000);
    check("t1_pulses", n_pulses - p0, 1);

    // multi-beat with memory backpressure, no ack
    rdy_mode = 2; pat_idx = 0;
    wlog.delete(); p0 = n_pulses;
    burst(32'h2008, 3, 0);
    idle(3);
    rdy_mode = 0;
    check("t2_writes", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      check("t2_addr", wlog[i], 32'h2008 + 32'(8 * i));
    check("t2_pulses", n_pulses - p0, 0);

    // unaligned base and address wrap
    wlog.delete();
    burst(32'hFFFF_FFFD, 1, 0);
    idle(2);
    check("t3_writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("t3_addr0", wlog[0], 32'hFFFF_FFF8);
      check("t3_addr1", wlog[1], 32'h0000_0000);
    end
    check("t3_no_err", proto_err, 0);

    // back-to-back acked single-beat commands, valid held throughout
    w0 = n_writes; p0 = n_pulses;
    for (int i = 0; i < 5; i++) begin
      send(cmd(32'h100 * i, 0, 1));
      send(dat(64'(i), 1'b1));
    end
    idle(3);
    check("t4_writes", n_writes - w0, 5);
    check("t4_pulses", n_pulses - p0, 5);

    // protocol errors
    w0 = n_writes;
    send(dat(64'h55, 1'b1));
    idle(2);
    check("t5_idle_dat_nowrite", n_writes - w0, 0);
    check("t5_err_set", proto_err, 1);
    wlog.delete();
    send(cmd(32'h4000, 2, 0));
    send(dat(64'h1, 1'b1));
    send(cmd(32'h9990, 5, 1));
    send(dat(64'h2, 1'b1));
    send(dat(64'h3, 1'b1));
    idle(3);
    check("t5_writes", wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      check("t5_addr", wlog[i], 32'h4000 + 32'(8 * i));
    check("t5_err_sticky", proto_err, 1);

    // reset mid-burst
    do_reset();
    idle(1);
    check("t6_err_cleared", proto_err, 0);
    p0 = n_pulses; wlog.delete();
    send(cmd(32'h5000, 7, 1));
    send(dat(64'hA, 1'b1));
    send(dat(64'hB, 1'b1));
    do_reset();
    idle(4);
    check("t6_no_pulse", n_pulses - p0, 0);
    check("t6_two_writes", wlog.size(), 2);
    wlog.delete(); p0 = n_pulses;
    send(cmd(32'h3000, 0, 1));
    send(dat(64'hDEADBEEF_00000001, 1'b1));
    idle(3);
    check("t6_fresh_writes", wlog.size(), 1);
    if (wlog.size() > 0) check("t6_fresh_addr", wlog[0], 32'h3000);
    check("t6_fresh_pulse", n_pulses - p0, 1);

    // randomized traffic, including occasional stray packets and mask errors
    for (int k = 0; k < 40; k++) begin
      int size;
      rdy_mode = $urandom_range(0, 2);
      size = $urandom_range(0, 5);
      if ($urandom_range(0, 9) == 0) send(dat({$urandom, $urandom}, 1'b1));
      send(cmd($urandom, size, 1'($urandom_range(0, 1))));
      for (int i = 0; i <= size; i++) begin
        if ($urandom_range(0, 14) == 0) send(cmd($urandom, 3, 1'b1));
        send(dat({$urandom, $urandom}, $urandom_range(0, 11) != 0));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
      end
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    idle(3);
    do_reset();
    idle(1);
    check("final_err_cleared", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
